mux8_bus_arbiter: RTL

Round-robin arbiter that shares one 8-input, 8-bit output-switched multiplexer among eight requesters. Each requester asks for the shared bus. The block grants one requester at a time, drives the mux `Selector` with the owner's index, and drives the mux `Disable` input. It enforces a one-cycle dead cycle between owners and a maximum hold time per grant. It sits between the LEG datapath units that contend for the shared 8-bit bus and the bus mux itself.

---
 rtl/mux8_bus_arbiter_if.sv | 31 +++
 rtl/mux8_bus_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/mux8_bus_arbiter_if.sv
// Shared-bus handshake between the requesters and the round-robin mux arbiter.
// The master side is the arbiter; the slave side is the requester/datapath side.
interface mux8_bus_arbiter_if;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] sel;
  logic       dis;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  modport master (
    input  req,
    input  done,
    output sel,
    output dis,
    output grant,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  sel,
    input  dis,
    input  grant,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/mux8_bus_arbiter.sv
// Round-robin owner of an 8:1 bus mux.
// Inserts a one-cycle dead cycle between owners and optionally caps hold time.
module mux8_bus_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mux8_bus_arbiter_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  localparam logic [7:0] HoldMaxL = 8'(HOLD_MAX);
  localparam logic       HoldEn   = (HOLD_MAX != 0);

  state_e     r_state;
  logic [2:0] r_last;
  logic [7:0] r_hold;
  logic [7:0] r_sel;
  logic [7:0] r_grant;
  logic       r_dis;
  logic       r_busy;
  logic       r_timeout;

  logic [2:0] w_owner;
  logic [2:0] w_winner;
  logic       w_any_req;
  logic       w_hold_hit;
  logic       w_norm_rel;

  // First set request after 'last', wrapping; 'last' itself is scanned last.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    w_owner    = r_sel[2:0];
    w_any_req  = |bus.req;
    w_winner   = rr_pick(bus.req, r_last);
    w_hold_hit = HoldEn && ((r_hold + 8'd1) == HoldMaxL);
    w_norm_rel = bus.done[w_owner] || !bus.req[w_owner];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= StIdle;
      r_last    <= 3'd7;
      r_hold    <= 8'd0;
      r_sel     <= 8'd0;
      r_grant   <= 8'd0;
      r_dis     <= 1'b1;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        StIdle, StRelease: begin
          if (w_any_req) begin
            r_state <= StGrant;
            r_last  <= w_winner;
            r_sel   <= {5'd0, w_winner};
            r_grant <= 8'd1 << w_winner;
            r_dis   <= 1'b0;
            r_busy  <= 1'b1;
            r_hold  <= 8'd0;
          end else if (r_state == StRelease) begin
            r_state <= StIdle;
          end
        end
        StGrant: begin
          r_hold <= r_hold + 8'd1;
          if (w_norm_rel || w_hold_hit) begin
            r_state   <= StRelease;
            r_grant   <= 8'd0;
            r_dis     <= 1'b1;
            r_busy    <= 1'b0;
            // A coincident done/req drop wins over the limit: no timeout.
            r_timeout <= !w_norm_rel;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.sel     = r_sel;
  assign bus.dis     = r_dis;
  assign bus.grant   = r_grant;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

endmodule
